// File: rtl/rf_mport.sv
// Multi-port register file: NR_RD combinational read ports, two write ports (B wins on collision),
// optional hardwired-zero entry 0, optional write-to-read bypass and a post-reset clear sweep.
module rf_mport #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned DEPTH   = 32,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned NR_RD   = 2,
    parameter bit          ZERO_R0 = 1'b1,
    parameter bit          BYPASS  = 1'b1
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [NR_RD*ADDR_W-1:0]   i_rd_addr,
    output logic [NR_RD*DATA_W-1:0]   o_rd_data,
    input  logic                      i_wa_en,
    input  logic [ADDR_W-1:0]         i_wa_addr,
    input  logic [DATA_W-1:0]         i_wa_data,
    input  logic                      i_wb_en,
    input  logic [ADDR_W-1:0]         i_wb_addr,
    input  logic [DATA_W-1:0]         i_wb_data,
    output logic                      o_init_busy,
    output logic                      o_wr_conflict
);

    typedef enum logic {StClear, StReady} state_e;

    state_e              r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_clr_ptr, w_clr_ptr_nxt;
    logic                r_wr_conflict, w_conflict_nxt;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic                w_clr_we, w_wa_we, w_wb_we;
    logic [ADDR_W-1:0]   w_ra;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= StClear;
            r_clr_ptr     <= '0;
            r_wr_conflict <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_clr_ptr     <= w_clr_ptr_nxt;
            r_wr_conflict <= w_conflict_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_ptr_nxt = r_clr_ptr;
        unique case (r_state)
            StClear: begin
                w_clr_ptr_nxt = r_clr_ptr + 1'b1;
                if (r_clr_ptr == ADDR_W'(DEPTH - 1)) begin
                    w_state_nxt   = StReady;
                    w_clr_ptr_nxt = '0;
                end
            end
            StReady: w_state_nxt = StReady;
        endcase
    end

    // Output / write-enable logic
    always_comb begin
        o_init_busy    = (r_state == StClear);
        w_clr_we       = (r_state == StClear) && !i_rst;
        w_wa_we        = (r_state == StReady) && !i_rst && i_wa_en
                         && !(ZERO_R0 && i_wa_addr == '0);
        w_wb_we        = (r_state == StReady) && !i_rst && i_wb_en
                         && !(ZERO_R0 && i_wb_addr == '0);
        w_conflict_nxt = w_wa_we && w_wb_we && (i_wa_addr == i_wb_addr);
    end

    assign o_wr_conflict = r_wr_conflict;

    // Port B is written last so it overrides A on an address collision
    always_ff @(posedge i_clk) begin
        if (w_clr_we) r_mem[r_clr_ptr] <= '0;
        if (w_wa_we)  r_mem[i_wa_addr] <= i_wa_data;
        if (w_wb_we)  r_mem[i_wb_addr] <= i_wb_data;
    end

    always_comb begin
        o_rd_data = '0;
        w_ra      = '0;
        for (int i = 0; i < NR_RD; i++) begin
            w_ra = i_rd_addr[i*ADDR_W +: ADDR_W];
            if (r_state == StReady && !(ZERO_R0 && w_ra == '0)) begin
                if (BYPASS && i_wb_en && i_wb_addr == w_ra) begin
                    o_rd_data[i*DATA_W +: DATA_W] = i_wb_data;
                end else if (BYPASS && i_wa_en && i_wa_addr == w_ra) begin
                    o_rd_data[i*DATA_W +: DATA_W] = i_wa_data;
                end else begin
                    o_rd_data[i*DATA_W +: DATA_W] = r_mem[w_ra];
                end
            end
        end
    end

endmodule

// File: tb/tb_rf_mport.sv
// Directed bench for rf_mport: default instance (bypass on) and a narrow 8-entry,
// 3-read-port instance with bypass off.
module tb_rf_mport;

    logic        clk;
    int          n_total = 0;
    int          n_bad   = 0;

    logic        rst0;
    logic [9:0]  rd_addr0;
    logic [63:0] rd_data0;
    logic        wa_en0, wb_en0;
    logic [4:0]  wa_addr0, wb_addr0;
    logic [31:0] wa_data0, wb_data0;
    logic        busy0, conf0;

    logic        rst1;
    logic [8:0]  rd_addr1;
    logic [47:0] rd_data1;
    logic        wa_en1, wb_en1;
    logic [2:0]  wa_addr1, wb_addr1;
    logic [15:0] wa_data1, wb_data1;
    logic        busy1, conf1;

    rf_mport u_dut0 (
        .i_clk(clk), .i_rst(rst0), .i_rd_addr(rd_addr0), .o_rd_data(rd_data0),
        .i_wa_en(wa_en0), .i_wa_addr(wa_addr0), .i_wa_data(wa_data0),
        .i_wb_en(wb_en0), .i_wb_addr(wb_addr0), .i_wb_data(wb_data0),
        .o_init_busy(busy0), .o_wr_conflict(conf0)
    );

    rf_mport #(
        .DATA_W(16), .DEPTH(8), .ADDR_W(3), .NR_RD(3), .ZERO_R0(1'b1), .BYPASS(1'b0)
    ) u_dut1 (
        .i_clk(clk), .i_rst(rst1), .i_rd_addr(rd_addr1), .o_rd_data(rd_data1),
        .i_wa_en(wa_en1), .i_wa_addr(wa_addr1), .i_wa_data(wa_data1),
        .i_wb_en(wb_en1), .i_wb_addr(wb_addr1), .i_wb_data(wb_data1),
        .o_init_busy(busy1), .o_wr_conflict(conf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst0 = 1'b1; rd_addr0 = '0; wa_en0 = 1'b0; wb_en0 = 1'b0;
        wa_addr0 = '0; wb_addr0 = '0; wa_data0 = '0; wb_data0 = '0;
        rst1 = 1'b1; rd_addr1 = '0; wa_en1 = 1'b0; wb_en1 = 1'b0;
        wa_addr1 = '0; wb_addr1 = '0; wa_data1 = '0; wb_data1 = '0;

        // 1: reset sweep, writes during sweep dropped
        step();
        chk("rst_busy", 32'(busy0), 32'd1);
        chk("rst_conf", 32'(conf0), 32'd0);
        rst0 = 1'b0;
        for (int k = 0; k < 32; k++) begin
            wa_en0 = 1'b1; wa_addr0 = 5'(k); wa_data0 = 32'h0BAD_0000 | 32'(k);
            wb_en0 = 1'b1; wb_addr0 = 5'(31 - k); wb_data0 = 32'h0F00_0000 | 32'(k);
            rd_addr0 = {5'(31 - k), 5'(k)};
            #1;
            chk("sweep_busy", 32'(busy0), 32'd1);
            if (k == 5) begin
                chk("sweep_rd0", rd_data0[31:0], 32'd0);
                chk("sweep_conf", 32'(conf0), 32'd0);
            end
            @(posedge clk);
            #1;
        end
        wa_en0 = 1'b0; wb_en0 = 1'b0;
        chk("sweep_done", 32'(busy0), 32'd0);
        for (int i = 0; i < 32; i++) begin
            rd_addr0 = {5'(i ^ 1), 5'(i)};
            #1;
            chk("clear_p0", rd_data0[31:0], 32'd0);
            chk("clear_p1", rd_data0[63:32], 32'd0);
        end
        step();

        // 2: reset mid-sweep
        wa_en0 = 1'b1; wa_addr0 = 5'd5; wa_data0 = 32'h1234;
        step();
        wa_en0 = 1'b0; rd_addr0 = {5'd0, 5'd5};
        #1;
        chk("pre_rst_r5", rd_data0[31:0], 32'h1234);
        rst0 = 1'b1; step(); rst0 = 1'b0;
        repeat (10) step();
        rst0 = 1'b1; step(); rst0 = 1'b0;
        for (int k = 0; k < 32; k++) begin
            chk("resweep_busy", 32'(busy0), 32'd1);
            step();
        end
        chk("resweep_done", 32'(busy0), 32'd0);
        #1;
        chk("post_rst_r5", rd_data0[31:0], 32'd0);
        step();

        // 3: basic write/read on both ports
        wa_en0 = 1'b1; wa_addr0 = 5'd3; wa_data0 = 32'hDEAD_BEEF;
        wb_en0 = 1'b1; wb_addr0 = 5'd7; wb_data0 = 32'h0000_CAFE;
        step();
        wa_en0 = 1'b0; wb_en0 = 1'b0; rd_addr0 = {5'd7, 5'd3};
        #1;
        chk("wr_r3", rd_data0[31:0], 32'hDEAD_BEEF);
        chk("wr_r7", rd_data0[63:32], 32'h0000_CAFE);
        chk("wr_noconf", 32'(conf0), 32'd0);

        // 4: conflict, then conflict on address 0
        wa_en0 = 1'b1; wa_addr0 = 5'd9; wa_data0 = 32'h11;
        wb_en0 = 1'b1; wb_addr0 = 5'd9; wb_data0 = 32'h22;
        rd_addr0 = {5'd9, 5'd9};
        #1;
        chk("byp_conf_r9", rd_data0[31:0], 32'h22);
        step();
        wa_en0 = 1'b0; wb_en0 = 1'b0;
        #1;
        chk("conf_pulse", 32'(conf0), 32'd1);
        chk("conf_r9", rd_data0[63:32], 32'h22);
        step();
        chk("conf_clear", 32'(conf0), 32'd0);
        wa_en0 = 1'b1; wa_addr0 = 5'd0; wa_data0 = 32'h33;
        wb_en0 = 1'b1; wb_addr0 = 5'd0; wb_data0 = 32'h44;
        rd_addr0 = {5'd0, 5'd0};
        #1;
        chk("byp_r0", rd_data0[31:0], 32'd0);
        step();
        wa_en0 = 1'b0; wb_en0 = 1'b0;
        #1;
        chk("r0_noconf", 32'(conf0), 32'd0);
        chk("r0_zero", rd_data0[63:32], 32'd0);

        // 5: bypass
        wa_en0 = 1'b1; wa_addr0 = 5'd4; wa_data0 = 32'hA5A5_A5A5;
        rd_addr0 = {5'd3, 5'd4};
        #1;
        chk("byp_a_r4", rd_data0[31:0], 32'hA5A5_A5A5);
        chk("byp_other", rd_data0[63:32], 32'hDEAD_BEEF);
        step();
        wa_data0 = 32'h1; wb_en0 = 1'b1; wb_addr0 = 5'd4; wb_data0 = 32'h2;
        rd_addr0 = {5'd4, 5'd4};
        #1;
        chk("byp_b_wins", rd_data0[31:0], 32'h2);
        step();
        wa_en0 = 1'b0; wb_en0 = 1'b0;
        #1;
        chk("r4_stored", rd_data0[63:32], 32'h2);
        chk("r4_conf", 32'(conf0), 32'd1);

        // 6: narrow instance, no bypass
        step();
        rst1 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("n_sweep_busy", 32'(busy1), 32'd1);
            step();
        end
        chk("n_sweep_done", 32'(busy1), 32'd0);
        wa_en1 = 1'b1; wa_addr1 = 3'd7; wa_data1 = 16'hFFFF;
        rd_addr1 = {3'd7, 3'd7, 3'd7};
        #1;
        chk("n_nobyp_r7", 32'(rd_data1[15:0]), 32'd0);
        step();
        wa_en1 = 1'b0;
        #1;
        chk("n_r7_p0", 32'(rd_data1[15:0]), 32'hFFFF);
        chk("n_r7_p1", 32'(rd_data1[31:16]), 32'hFFFF);
        chk("n_r7_p2", 32'(rd_data1[47:32]), 32'hFFFF);
        wa_en1 = 1'b1; wa_addr1 = 3'd2; wa_data1 = 16'h1111;
        wb_en1 = 1'b1; wb_addr1 = 3'd2; wb_data1 = 16'h2222;
        rd_addr1 = {3'd2, 3'd2, 3'd2};
        #1;
        chk("n_nobyp_r2", 32'(rd_data1[15:0]), 32'd0);
        step();
        wa_en1 = 1'b0; wb_en1 = 1'b0;
        #1;
        chk("n_r2_b", 32'(rd_data1[31:16]), 32'h2222);
        chk("n_conf", 32'(conf1), 32'd1);
        step();
        chk("n_conf_clear", 32'(conf1), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
